// File: rtl/mmio_pkg.sv
// Shared definitions for the CPU data-port MMIO bridge: register word offsets,
// UART serializer states and UART_STATUS bit positions.
package mmio_pkg;

  // Word offsets within the MMIO page, compared against d_addr[7:1]
  localparam logic [6:0] UART_DATA   = 7'h00;
  localparam logic [6:0] UART_STATUS = 7'h01;
  localparam logic [6:0] LED         = 7'h02;
  localparam logic [6:0] CYCLE_LO    = 7'h03;
  localparam logic [6:0] CYCLE_HI    = 7'h04;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  function automatic logic [ST_CNT_W-1:0] sat_count(input logic [7:0] n);
    return (n > 8'd15) ? 4'hF : n[ST_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/uart_tx.sv
// Buffered 8N1 transmitter: FIFO feeding an LSB-first serializer, one frame every 10*CLK_DIV cycles.
// A push into a full FIFO is dropped (flagged on drop) unless a pop happens in the same cycle.
module uart_tx
  import mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 434
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  logic [7:0]                          push_data,
  output logic                                txd,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
  output logic                                busy,
  output logic                                drop
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ;
  uart_state_t   state;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_end, pop, push_ok;

  assign full    = (occ == CW'(FIFO_DEPTH));
  assign empty   = (occ == '0);
  assign count   = occ;
  assign busy    = (state != IDLE);
  assign bit_end = (div_cnt == DW'(CLK_DIV - 1));
  // The end of a stop bit doubles as an idle slot, so queued bytes go out back-to-back
  assign pop     = !empty && ((state == IDLE) || (state == STOP && bit_end));
  assign push_ok = push && (!full || pop);
  assign drop    = push && !push_ok;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else if (pop) begin
      state   <= START;
      shift   <= mem[rd_ptr];
      div_cnt <= '0;
      txd     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div_cnt <= '0;
          txd     <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            div_cnt <= '0;
            bit_idx <= '0;
            txd     <= shift[0];
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              txd     <= shift[1];
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            state   <= IDLE;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// Splits CPU data accesses between RAM passthrough and a 256-byte MMIO page (UART, LEDs, cycle counter).
// Reads return combinationally in the access cycle; there is no backpressure, UART overflow is sticky.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter logic [15:0] MMIO_BASE  = 16'hFF00,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CLK_DIV    = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  input  logic [15:0] d_dout,
  input  logic [1:0]  d_we,
  output logic [15:0] d_din,
  output logic [15:0] ram_addr,
  output logic        ram_oe,
  output logic [15:0] ram_wdata,
  output logic [1:0]  ram_we,
  input  logic [15:0] ram_rdata,
  output logic        uart_txd,
  output logic [15:0] led
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          mmio, push, drop, cnt_clr, ovf_clr;
  logic          fifo_full, fifo_empty, tx_busy, overflow;
  logic [6:0]    word;
  logic [CW-1:0] fifo_count;
  logic [31:0]   counter;
  logic [15:0]   shadow, status, reg_rdata;

  assign mmio = (d_addr[15:8] == MMIO_BASE[15:8]);
  assign word = d_addr[7:1];

  assign ram_addr  = d_addr;
  assign ram_wdata = d_dout;
  assign ram_oe    = d_oe & ~mmio;
  assign ram_we    = mmio ? 2'b00 : d_we;
  assign d_din     = mmio ? reg_rdata : ram_rdata;

  // Byte-lane 1 carries d_dout[7:0], so only it can push or clear overflow
  assign push    = mmio && (word == UART_DATA) && d_we[1];
  assign ovf_clr = mmio && (word == UART_STATUS) && d_we[1] && d_dout[ST_OVF];
  assign cnt_clr = mmio && (|d_we) && ((word == CYCLE_LO) || (word == CYCLE_HI));

  uart_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CLK_DIV    (CLK_DIV)
  ) u_uart_tx (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (d_dout[7:0]),
    .txd       (uart_txd),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .busy      (tx_busy),
    .drop      (drop)
  );

  always_comb begin
    status                                = '0;
    status[ST_EMPTY]                      = fifo_empty;
    status[ST_FULL]                       = fifo_full;
    status[ST_BUSY]                       = tx_busy;
    status[ST_OVF]                        = overflow;
    status[ST_CNT_LSB +: ST_CNT_W]        = sat_count(8'(fifo_count));
  end

  always_comb begin
    reg_rdata = '0;
    case (word)
      UART_STATUS: reg_rdata = status;
      LED:         reg_rdata = led;
      CYCLE_LO:    reg_rdata = counter[15:0];
      CYCLE_HI:    reg_rdata = shadow;
      default:     ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led      <= '0;
      counter  <= '0;
      shadow   <= '0;
      overflow <= 1'b0;
    end else begin
      if (mmio && (word == LED)) begin
        if (d_we[0]) led[15:8] <= d_dout[15:8];
        if (d_we[1]) led[7:0]  <= d_dout[7:0];
      end
      // Reading the low half freezes the high half so a LO-then-HI pair cannot tear
      if (mmio && (word == CYCLE_LO) && d_oe) shadow <= counter[31:16];
      counter <= cnt_clr ? '0 : counter + 32'd1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: per-cycle bus expectations and decoded UART frames
// are predicted by a transaction-level model and checked by independent monitors.
module tb_mmio_bridge;

  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_addr, d_dout, ram_rdata;
  logic        d_oe;
  logic [1:0]  d_we;
  logic [15:0] d_din, ram_addr, ram_wdata, led;
  logic        ram_oe, uart_txd;
  logic [1:0]  ram_we;

  mmio_bridge #(
    .MMIO_BASE  (16'hFF00),
    .FIFO_DEPTH (DEPTH),
    .CLK_DIV    (DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d_addr    (d_addr),
    .d_oe      (d_oe),
    .d_dout    (d_dout),
    .d_we      (d_we),
    .d_din     (d_din),
    .ram_addr  (ram_addr),
    .ram_oe    (ram_oe),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .uart_txd  (uart_txd),
    .led       (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  din, addr, wdata, led;
    logic         oe;
    logic [1:0]   we;
    bit           chk_txd;
    logic [127:0] name;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  exp_t   exp_q[$];
  frame_t frame_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, rst_cnt = 0, frames_done = 0;
  bit mon_en = 1'b0;

  // Reference model: byte queue, cycles left in the frame on the wire, plain registers
  logic [7:0]  m_fifo[$];
  int          m_remain = 0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_led = '0, m_shadow = '0;
  logic [31:0] m_cnt = '0;

  task automatic model_step();
    logic       mm;
    logic [6:0] w;
    frame_t     f;
    cyc++;
    if (rst) begin
      m_fifo.delete();
      frame_q.delete();
      m_remain = 0;
      m_ovf    = 1'b0;
      m_led    = '0;
      m_shadow = '0;
      m_cnt    = '0;
      rst_cnt++;
      return;
    end
    mm = (d_addr[15:8] == 8'hFF);
    w  = d_addr[7:1];
    if (m_remain <= 1 && m_fifo.size() > 0) begin
      f.b     = m_fifo.pop_front();
      f.start = cyc;
      frame_q.push_back(f);
      m_remain = FRAME;
    end else if (m_remain > 0) begin
      m_remain--;
    end
    if (mm && w == 7'd0 && d_we[1]) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(d_dout[7:0]);
      else m_ovf = 1'b1;
    end
    if (mm && w == 7'd1 && d_we[1] && d_dout[3]) m_ovf = 1'b0;
    if (mm && w == 7'd2) begin
      if (d_we[0]) m_led[15:8] = d_dout[15:8];
      if (d_we[1]) m_led[7:0]  = d_dout[7:0];
    end
    if (mm && w == 7'd3 && d_oe) m_shadow = m_cnt[31:16];
    if (mm && (w == 7'd3 || w == 7'd4) && d_we != 2'b00) m_cnt = '0;
    else m_cnt = m_cnt + 32'd1;
  endtask

  function automatic logic [15:0] model_read(input logic [6:0] w);
    logic [3:0] n;
    n = 4'(m_fifo.size());
    case (w)
      7'd1: return {8'h00, n, m_ovf, 1'(m_remain > 0), 1'(m_fifo.size() == DEPTH), 1'(m_fifo.size() == 0)};
      7'd2: return m_led;
      7'd3: return m_cnt[15:0];
      7'd4: return m_shadow;
      default: return 16'h0000;
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic drive(input logic [15:0] a, input logic oe, input logic [1:0] we,
                       input logic [15:0] dout, input logic [15:0] rd, input logic r,
                       input bit chk_txd, input logic [127:0] name);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; d_addr = a; d_oe = oe; d_we = we; d_dout = dout; ram_rdata = rd;
    if (a[15:8] == 8'hFF) begin
      e.din = model_read(a[7:1]); e.oe = 1'b0; e.we = 2'b00;
    end else begin
      e.din = rd; e.oe = oe; e.we = we;
    end
    e.addr = a; e.wdata = dout; e.led = m_led; e.chk_txd = chk_txd; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(16'h0000, 1'b0, 2'b00, 16'h0000, 16'($urandom), 1'b0, 1'b0, "idle");
  endtask

  task automatic chk(input logic [127:0] name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %0s: got %h, expected %h", name, act, want);
    end
  endtask

  // Bus monitor: one expectation per driven cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (d_din !== e.din || ram_oe !== e.oe || ram_we !== e.we || ram_addr !== e.addr ||
            ram_wdata !== e.wdata || led !== e.led || (e.chk_txd && uart_txd !== 1'b1)) begin
          errors++;
          $display("FAIL %0s: d_din=%h ram_oe=%b ram_we=%b ram_addr=%h ram_wdata=%h led=%h txd=%b; expected d_din=%h ram_oe=%b ram_we=%b ram_addr=%h ram_wdata=%h led=%h txd=%s",
                   e.name, d_din, ram_oe, ram_we, ram_addr, ram_wdata, led, uart_txd,
                   e.din, e.oe, e.we, e.addr, e.wdata, e.led, e.chk_txd ? "1" : "any");
        end
      end
    end
  end

  // UART monitor: decode frames mid-bit and match byte and start cycle against the model
  initial begin
    logic [7:0] b;
    logic       st, sp;
    int         s, rc;
    frame_t     f;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (uart_txd === 1'b0) begin
        s = cyc; rc = rst_cnt;
        repeat (DIV / 2) @(negedge clk);
        st = uart_txd;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (DIV) @(negedge clk);
        sp = uart_txd;
        repeat (DIV / 2 - 1) @(negedge clk);
        if (rc == rst_cnt) begin
          checks++;
          if (frame_q.size() == 0) begin
            errors++;
            $display("FAIL uart_frame: got unexpected frame byte %h at cycle %0d, expected no frame", b, s);
          end else begin
            f = frame_q.pop_front();
            if (b !== f.b || s != f.start || st !== 1'b0 || sp !== 1'b1) begin
              errors++;
              $display("FAIL uart_frame: got byte %h start %0d startbit %b stopbit %b, expected byte %h start %0d startbit 0 stopbit 1",
                       b, s, st, sp, f.b, f.start);
            end
          end
          frames_done++;
        end
      end
    end
  end

  initial begin
    logic [15:0] a;
    int          frames_at_rst;
    rst = 1'b1; d_addr = '0; d_oe = 1'b0; d_we = 2'b00; d_dout = '0; ram_rdata = '0;
    repeat (3) @(posedge clk);
    mon_en = 1'b1;

    // Reset state, sampled while rst is still held
    drive(16'hFF02, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, "rst_status");
    @(negedge clk); chk("rst_status_val", 32'(d_din), 32'h0001);
    drive(16'hFF06, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, "rst_cycle_lo");
    drive(16'hFF08, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, "rst_cycle_hi");

    // LED byte lanes
    drive(16'hFF04, 1'b0, 2'b01, 16'hAB00, 16'h1111, 1'b0, 1'b0, "led_hi_wr");
    drive(16'hFF05, 1'b0, 2'b10, 16'h00CD, 16'h2222, 1'b0, 1'b0, "led_lo_wr");
    @(negedge clk); chk("led_lo_ram_we", 32'(ram_we), 32'h0);
    drive(16'hFF04, 1'b1, 2'b00, 16'h0000, 16'h3333, 1'b0, 1'b0, "led_read");
    @(negedge clk); chk("led_read_val", 32'(d_din), 32'hABCD);

    // RAM passthrough
    drive(16'h1234, 1'b1, 2'b00, 16'h0000, 16'h5A5A, 1'b0, 1'b0, "ram_read");
    @(negedge clk); chk("ram_read_din", 32'(d_din), 32'h5A5A);
    drive(16'h0010, 1'b0, 2'b11, 16'hBEEF, 16'h0000, 1'b0, 1'b0, "ram_write");
    drive(16'hFF10, 1'b1, 2'b00, 16'h0000, 16'h7777, 1'b0, 1'b0, "mmio_unmapped");
    @(negedge clk); chk("mmio_unmapped_oe", 32'(ram_oe), 32'h0);

    // Single frame, then status during and after
    drive(16'hFF00, 1'b0, 2'b11, 16'h0041, 16'h0000, 1'b0, 1'b0, "uart_wr_41");
    idle(20);
    drive(16'hFF02, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, "status_busy");
    @(negedge clk); chk("status_busy_val", 32'(d_din), 32'h0005);
    idle(30);
    drive(16'hFF02, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, "status_done");
    @(negedge clk); chk("status_done_val", 32'(d_din), 32'h0001);

    // Overflow: 10 back-to-back pushes
    for (int i = 0; i < 10; i++)
      drive(16'hFF00, 1'b0, 2'b11, 16'(16'h0060 + i), 16'h0000, 1'b0, 1'b0, "uart_burst");
    drive(16'hFF02, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, "status_ovf");
    @(negedge clk); chk("status_ovf_val", 32'(d_din), 32'h008E);
    drive(16'hFF02, 1'b0, 2'b11, 16'h0008, 16'h0000, 1'b0, 1'b0, "ovf_clear");
    drive(16'hFF02, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, "status_clr");
    @(negedge clk); chk("status_clr_val", 32'(d_din), 32'h0086);
    idle(9 * FRAME + 20);
    chk("burst_frames", 32'(frames_done), 32'd10);

    // Randomized mix of RAM and MMIO traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) a = {8'($urandom_range(0, 254)), 8'($urandom)};
      else a = {8'hFF, 8'($urandom_range(0, 15))};
      drive(a, 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0, "random");
    end

    // Cycle counter across the 16-bit rollover
    drive(16'hFF06, 1'b0, 2'b11, 16'h0000, 16'h0000, 1'b0, 1'b0, "cnt_clear");
    idle(70000);
    drive(16'hFF06, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, "cnt_lo");
    drive(16'hFF08, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, "cnt_hi");
    @(negedge clk); chk("cnt_hi_val", 32'(d_din), 32'h0001);
    idle(FRAME * 12);

    // Reset in the middle of a frame with bytes still queued
    for (int i = 0; i < 4; i++)
      drive(16'hFF00, 1'b0, 2'b11, 16'(16'h00A0 + i), 16'h0000, 1'b0, 1'b0, "uart_pre_rst");
    drive(16'hFF04, 1'b0, 2'b11, 16'h5AA5, 16'h0000, 1'b0, 1'b0, "led_pre_rst");
    idle(10);
    drive(16'h0000, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, "rst_assert");
    drive(16'hFF02, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, "mid_rst_status");
    @(negedge clk);
    chk("mid_rst_status_val", 32'(d_din), 32'h0001);
    chk("mid_rst_txd", 32'(uart_txd), 32'h1);
    drive(16'hFF06, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, "mid_rst_cnt");
    @(negedge clk); chk("mid_rst_cnt_val", 32'(d_din), 32'h0000);
    drive(16'hFF04, 1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b1, "mid_rst_led");
    frames_at_rst = frames_done;
    idle(FRAME * 5);
    chk("no_frames_after_rst", 32'(frames_done), 32'(frames_at_rst));
    chk("frames_outstanding", 32'(frame_q.size()), 32'd0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
